// File: rtl/max_scan_pkg.sv
// Shared types for the max-scan reduction engine.
package max_scan_pkg;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;
  localparam int RD_LAT = 1;
endpackage

// File: rtl/max_scan_ctrl_if.sv
// Request/result handshake plus single-port memory bus of the max-scan engine.
interface max_scan_ctrl_if #(parameter int WIDTH = 16, parameter int SIZE = 1024);
  localparam int LOGSIZE = $clog2(SIZE);
  logic               start;
  logic [LOGSIZE-1:0] base_addr;
  logic [LOGSIZE:0]   length;
  logic [LOGSIZE-1:0] dst_addr;
  logic               wb_en;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   max_val;
  logic [LOGSIZE-1:0] max_idx;
  logic [LOGSIZE-1:0] mem_addr;
  logic               mem_we;
  logic [WIDTH-1:0]   mem_wdata;
  logic [WIDTH-1:0]   mem_rdata;

  modport master (output start, base_addr, length, dst_addr, wb_en, mem_rdata,
                  input  busy, done, max_val, max_idx, mem_addr, mem_we, mem_wdata);
  modport slave  (input  start, base_addr, length, dst_addr, wb_en, mem_rdata,
                  output busy, done, max_val, max_idx, mem_addr, mem_we, mem_wdata);
endinterface

// File: rtl/max_scan_ctrl_tracker.sv
// Running maximum with offset; first valid word loads, then strict-greater only
// so ties keep the lowest offset.
module max_tracker #(parameter int WIDTH = 16, parameter int IDXW = 10) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  logic [IDXW-1:0]  offset,
  output logic [WIDTH-1:0] max_val,
  output logic [IDXW-1:0]  max_idx,
  output logic [WIDTH-1:0] next_val
);
  logic first;
  logic take;

  assign take     = valid && (first || (data > max_val));
  // Lets the write-back stage capture the final max in the same cycle it is consumed.
  assign next_val = take ? data : max_val;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      max_val <= '0;
      max_idx <= '0;
      first   <= 1'b1;
    end else if (take) begin
      max_val <= data;
      max_idx <= offset;
      first   <= 1'b0;
    end
  end
endmodule

// File: rtl/max_scan_ctrl.sv
// Scans a wrapping address window of a sync-read memory, tracks the maximum and
// optionally writes it back to a destination address.
module max_scan_ctrl
  import max_scan_pkg::*;
#(parameter int WIDTH = 16, parameter int SIZE = 1024) (
  input logic clk,
  input logic reset,
  max_scan_ctrl_if.slave bus
);
  localparam int LOGSIZE = $clog2(SIZE);
  localparam logic [LOGSIZE:0] SIZE_W = (LOGSIZE+1)'(SIZE);
  localparam logic [LOGSIZE:0] ONE    = (LOGSIZE+1)'(1);

  state_t             state;
  logic [LOGSIZE-1:0] base_q, dst_q, rd_off, nxt_addr;
  logic [LOGSIZE:0]   len_q, cnt, len_clamp, nxt_cnt, sum;
  logic               wb_q, rd_valid, clear;
  logic [WIDTH-1:0]   next_val;

  always_comb begin
    len_clamp = (bus.length > SIZE_W) ? SIZE_W : bus.length;
    nxt_cnt   = cnt + ONE;
    sum       = {1'b0, base_q} + nxt_cnt;
    nxt_addr  = (sum >= SIZE_W) ? LOGSIZE'(sum - SIZE_W) : sum[LOGSIZE-1:0];
  end

  assign clear = (state == IDLE) && bus.start;

  max_tracker #(.WIDTH(WIDTH), .IDXW(LOGSIZE)) u_trk (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .valid    (rd_valid),
    .data     (bus.mem_rdata),
    .offset   (rd_off),
    .max_val  (bus.max_val),
    .max_idx  (bus.max_idx),
    .next_val (next_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      base_q        <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      wb_q          <= 1'b0;
      cnt           <= '0;
      rd_valid      <= 1'b0;
      rd_off        <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.mem_we <= 1'b0;
      // Read data returns one cycle after its address, so qualify it a cycle late.
      rd_valid   <= (state == READ);
      rd_off     <= cnt[LOGSIZE-1:0];
      case (state)
        IDLE: if (bus.start) begin
          base_q <= bus.base_addr;
          dst_q  <= bus.dst_addr;
          wb_q   <= bus.wb_en;
          len_q  <= len_clamp;
          cnt    <= '0;
          if (len_clamp == '0) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state        <= READ;
            bus.busy     <= 1'b1;
            bus.mem_addr <= bus.base_addr;
          end
        end
        READ: begin
          if (cnt == len_q - ONE) begin
            state        <= DRAIN;
            bus.mem_addr <= '0;
          end else begin
            cnt          <= nxt_cnt;
            bus.mem_addr <= nxt_addr;
          end
        end
        DRAIN: begin
          if (wb_q) begin
            state         <= WRITE;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= dst_q;
            bus.mem_wdata <= next_val;
          end else begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        WRITE: begin
          state         <= DONE;
          bus.busy      <= 1'b0;
          bus.done      <= 1'b1;
          bus.mem_addr  <= '0;
          bus.mem_wdata <= '0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_max_scan_ctrl.sv
// Table-driven bench for max_scan_ctrl with a behavioural sync-read memory.
module tb_max_scan_ctrl;
  localparam int WIDTH = 16;
  localparam int SIZE  = 1024;

  typedef enum int {F_RAMP, F_PEAK, F_ZERO, F_TIE} fill_t;
  typedef struct {
    fill_t fill;
    int    base;
    int    len;
    int    dst;
    bit    wb;
    int    exp_val;
    int    exp_idx;
    int    exp_cyc;
    int    exp_wr;
  } vec_t;
  typedef struct {
    int val;
    int idx;
    int cyc;
    int wr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [WIDTH-1:0] mem [SIZE];
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];
  vec_t vecs[8];

  max_scan_ctrl_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();
  max_scan_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  task automatic fill(input fill_t f);
    for (int i = 0; i < SIZE; i++) begin
      case (f)
        F_RAMP:  mem[i] = WIDTH'(i);
        F_PEAK:  mem[i] = WIDTH'(i % 256);
        default: mem[i] = '0;
      endcase
    end
    if (f == F_PEAK) mem[1022] = 16'hABCD;
    if (f == F_TIE) begin
      mem[100] = 16'h7; mem[101] = 16'h9; mem[102] = 16'h9; mem[103] = 16'h1;
    end
  endtask

  task automatic drive_start(input int base, input int len, input int dst, input bit wb);
    bus.start     = 1'b1;
    bus.base_addr = 10'(base);
    bus.length    = 11'(len);
    bus.dst_addr  = 10'(dst);
    bus.wb_en     = wb;
  endtask

  task automatic run(input vec_t v);
    int n, cyc, wr, bus_err, busy_err;
    bit got;
    exp_t e;
    n = (v.len > SIZE) ? SIZE : v.len;
    fill(v.fill);
    @(negedge clk);
    drive_start(v.base, v.len, v.dst, v.wb);
    sb.push_back('{v.exp_val, v.exp_idx, v.exp_cyc, v.exp_wr});
    cyc = 0; wr = 0; bus_err = 0; busy_err = 0; got = 1'b0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        // scramble request inputs; the engine must use its latched copy
        bus.start = 1'b0;
        drive_start(int'($urandom_range(0, SIZE-1)), int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, SIZE-1)), ~v.wb);
        bus.start = 1'b0;
      end
      if (cyc <= n && (int'(bus.mem_addr) != (v.base + cyc - 1) % SIZE || bus.mem_we)) bus_err++;
      if (bus.mem_we) wr++;
      if (bus.done) begin
        got = 1'b1;
        if (bus.mem_addr != '0 || bus.mem_wdata != '0 || bus.busy) bus_err++;
      end else if (!bus.busy) busy_err++;
    end
    chk("done_seen", int'(got), 1);
    e = sb.pop_front();
    chk("done_cycle", cyc, e.cyc);
    chk("max_val", int'(bus.max_val), e.val);
    chk("max_idx", int'(bus.max_idx), e.idx);
    chk("write_cycles", wr, e.wr);
    chk("bus_seq_errors", bus_err, 0);
    chk("busy_errors", busy_err, 0);
    @(negedge clk);
    chk("hold_max_val", int'(bus.max_val), e.val);
    if (v.wb && e.wr > 0) chk("mem_dst", int'(mem[v.dst]), e.val);
  endtask

  initial begin
    int done_cyc[2];
    int nd, busy7, busy8, addr8, bad_mem, seen_done, seen_we;

    vecs[0] = '{F_RAMP, 0,    1024, 5,   1'b1, 1023,    1023, 1027, 1};
    vecs[1] = '{F_PEAK, 1020, 8,    0,   1'b0, 'hABCD,  2,    10,   0};
    vecs[2] = '{F_ZERO, 100,  4,    0,   1'b0, 0,       0,    6,    0};
    vecs[3] = '{F_TIE,  100,  4,    900, 1'b1, 9,       1,    7,    1};
    vecs[4] = '{F_RAMP, 10,   0,    3,   1'b1, 0,       0,    1,    0};
    vecs[5] = '{F_RAMP, 10,   2000, 0,   1'b0, 1023,    1013, 1026, 0};
    vecs[6] = '{F_RAMP, 512,  3,    1000,1'b1, 514,     2,    6,    1};
    vecs[7] = '{F_RAMP, 1023, 2,    0,   1'b0, 1023,    0,    4,    0};

    reset = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.dst_addr = '0; bus.wb_en = 1'b0;
    fill(F_RAMP);
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({bus.busy, bus.done, bus.mem_we}), 0);
    chk("reset_bus", int'(bus.mem_addr) + int'(bus.mem_wdata) + int'(bus.max_val) + int'(bus.max_idx), 0);
    reset = 1'b0;

    foreach (vecs[i]) run(vecs[i]);

    // start held high through the run and into DONE: restart only from the next IDLE
    fill(F_TIE);
    @(negedge clk);
    drive_start(100, 4, 0, 1'b0);
    nd = 0; busy7 = -1; busy8 = -1; addr8 = -1;
    for (int c = 1; c <= 20 && nd < 2; c++) begin
      @(negedge clk);
      if (bus.done) begin done_cyc[nd] = c; nd++; end
      if (c == 7) busy7 = int'(bus.busy);
      if (c == 8) begin busy8 = int'(bus.busy); addr8 = int'(bus.mem_addr); bus.start = 1'b0; end
    end
    chk("held_done_count", nd, 2);
    chk("held_first_done", (nd > 0) ? done_cyc[0] : -1, 6);
    chk("held_busy_c7", busy7, 0);
    chk("held_busy_c8", busy8, 1);
    chk("held_addr_c8", addr8, 100);
    chk("held_second_done", (nd > 1) ? done_cyc[1] : -1, 13);
    chk("held_max_idx", int'(bus.max_idx), 1);

    // reset in the middle of a write-back scan
    fill(F_RAMP);
    @(negedge clk);
    drive_start(0, 100, 7, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_ctl", int'({bus.busy, bus.done, bus.mem_we}), 0);
    chk("midreset_bus", int'(bus.mem_addr) + int'(bus.mem_wdata) + int'(bus.max_val) + int'(bus.max_idx), 0);
    reset = 1'b0;
    seen_done = 0; seen_we = 0;
    repeat (120) begin
      @(negedge clk);
      if (bus.done) seen_done++;
      if (bus.mem_we) seen_we++;
    end
    chk("midreset_no_done", seen_done, 0);
    chk("midreset_no_write", seen_we, 0);
    bad_mem = 0;
    for (int i = 0; i < SIZE; i++) if (mem[i] != WIDTH'(i)) bad_mem++;
    chk("midreset_mem_intact", bad_mem, 0);
    run(vecs[6]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
